rs_chien_seq: RTL and testbench
===============================

# rs_chien_seq

Parametrised, multicycle Chien search for the RS decoder back-end. It takes one error-locator polynomial Λ(x) per transaction through a valid/ready handshake and evaluates Λ(α^-p) for every codeword position p = 0..N_LEN-1, P positions per cycle, using per-coefficient update registers. It returns the ascending list of error positions, the root count and a decode-failure flag, held under a valid/ready handshake. It sits between the Berlekamp-Massey stage and the Forney/correction stage, and supports shortened codes, throughput/area trade-off via P, and optional early termination.

## Interface
- SYMB_WIDTH, 8, symbol width m; field GF(2^m).
- PRIM_POLY, 'h11D, primitive polynomial including the x^m term.
- T_LEN, 8, correction capability; Λ has T_LEN+1 coefficients.
- N_LEN, 255, codeword length, 1..2^m-1; values below 2^m-1 denote a shortened code.
- P, 8, positions evaluated per cycle, 1..N_LEN.
- EARLY_STOP, 0, 1 = finish as soon as the root count equals deg Λ.
- POS_W, derived, $clog2(N_LEN).
- CNT_W, derived, $clog2(T_LEN+2).
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- lambda_i  in  (T_LEN+1)*SYMB_WIDTH  Λ coefficients; Λ_j at [j*SYMB_WIDTH +: SYMB_WIDTH].
- in_valid  in  1  lambda_i valid.
- in_ready  out  1  block can accept a polynomial.
- err_pos_o  out  T_LEN*POS_W  error positions; slot k at [k*POS_W +: POS_W], ascending order.
- err_pos_vld_o  out  T_LEN  per-slot valid mask, filled from LSB.
- err_cnt_o  out  CNT_W  roots found, saturating at T_LEN+1.
- fail_o  out  1  uncorrectable block.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- The FSM has three states: IDLE, EVAL and DONE. `in_ready = (state==IDLE)`. `out_valid = (state==DONE)`.
- **IDLE:** on in_valid & in_ready:
  - Load R_j ← Λ_j for j = 0..T_LEN.
  - Compute deg Λ as the highest nonzero index.
  - Clear the count, slots and mask; set base ← 0.
  - Go to EVAL.
- **EVAL, per cycle:**
  - For lane i = 0..P-1, p = base+i, v_i = Σ_j R_j·α^(-j·i). Lane i is a root iff v_i == 0 and p < N_LEN.
  - Update R_j ← R_j·α^(-j·P). Constant multipliers are derived at elaboration from PRIM_POLY.
  - Update base ← base+P.
- **Root insertion:** roots within a cycle are inserted in lane order into the next free slots, so positions stay ascending. The count adds the number of lane roots and saturates at T_LEN+1. Roots beyond T_LEN slots are counted but not stored.
- **EVAL exit:** leave EVAL after the cycle in which base+P ≥ N_LEN. With EARLY_STOP=1, also leave after the cycle in which the updated count == deg Λ and deg Λ > 0.
- **fail_o** is computed on entry to DONE as (Λ_0 == 0) | (count != deg Λ).
  - Λ = 1 (deg 0): count 0, fail 0.
  - Λ all zero: fail 1.
- **DONE:** outputs are stable and held while out_ready is low. On out_ready, go to IDLE. A new input can be accepted no earlier than the cycle after release; there is no overlap.
- Unused slots read 0 with their mask bit 0.
- The last EVAL cycle masks lanes with p ≥ N_LEN, so wrap-around roots are never reported.
- in_valid while not in_ready is ignored, and lambda_i is not sampled.

## Timing
- **Reset values** (asynchronous, any state): state IDLE, in_ready 1, out_valid 0, err_pos_o 0, err_pos_vld_o 0, err_cnt_o 0, fail_o 0, internal R_j 0.
- **Accept edge (E0):** input handshake at clock edge E0; EVAL cycles 1..C with C = ceil(N_LEN/P).
- **Latency:** out_valid rises at edge E0+C+1. With EARLY_STOP=1, it rises at edge E0+k+1, where k is the cycle in which the last root is found.
- **Throughput:** one polynomial per C+2 cycles with out_ready tied high.
- Reset asserted mid-EVAL or mid-DONE discards the transaction; there is no output pulse.
- in_ready falls the cycle after the accept edge and returns the cycle after the output handshake.

## Test plan
- **No errors:** N_LEN=255, P=8, Λ=1 → out_valid at E0+33, count 0, mask 0, fail 0.
- **Single error:** Λ = 1+α^5·x → slot0 = 5, mask 'b1, count 1, fail 0. Repeat with EARLY_STOP=1 → out_valid at E0+2.
- **Three errors:** Λ = (1+α^3x)(1+α^100x)(1+α^254x) → slots {3,100,254}, count 3, fail 0. Sweep P ∈ {1,3,8,255} for identical results and latency ceil(255/P)+1.
- **Shortened code:** N_LEN=200, Λ = (1+α^3x)(1+α^250x) → slot0 = 3, count 1, fail 1. Separately, Λ_0 = 0 → fail 1.
- **Backpressure:** hold out_ready low for 10 cycles after out_valid → outputs stable, in_ready 0, second in_valid not accepted. Release → out_valid drops next cycle and in_ready rises.
- **Reset mid-EVAL:** assert aresetn low during cycle 5 of EVAL → all outputs at reset values. The next Λ decodes correctly.

Source files
------------

// File: rtl/rs_chien_seq_if.sv
// Handshake bundle for the multicycle Chien search.
//   master : upstream/downstream side (drives lambda_i, in_valid, out_ready)
//   slave  : rs_chien_seq side (drives in_ready, results, out_valid)
// Ports:
//   lambda_i      Λ coefficients, Λ_j at [j*SYMB_WIDTH +: SYMB_WIDTH]
//   in_valid      lambda_i valid
//   in_ready      block can accept a polynomial
//   err_pos_o     error positions, slot k at [k*POS_W +: POS_W], ascending
//   err_pos_vld_o per-slot valid mask, filled from LSB
//   err_cnt_o     roots found, saturating at T_LEN+1
//   fail_o        uncorrectable block
//   out_valid     result valid
//   out_ready     downstream accepts the result
interface rs_chien_seq_if #(
  parameter int unsigned SYMB_WIDTH = 8,
  parameter int unsigned T_LEN      = 8,
  parameter int unsigned N_LEN      = 255
);
  localparam int unsigned POS_W = (N_LEN > 1) ? $clog2(N_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(T_LEN + 2);

  logic [(T_LEN+1)*SYMB_WIDTH-1:0] lambda_i;
  logic                            in_valid;
  logic                            in_ready;
  logic [T_LEN*POS_W-1:0]          err_pos_o;
  logic [T_LEN-1:0]                err_pos_vld_o;
  logic [CNT_W-1:0]                err_cnt_o;
  logic                            fail_o;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    output lambda_i, in_valid, out_ready,
    input  in_ready, err_pos_o, err_pos_vld_o, err_cnt_o, fail_o, out_valid
  );

  modport slave (
    input  lambda_i, in_valid, out_ready,
    output in_ready, err_pos_o, err_pos_vld_o, err_cnt_o, fail_o, out_valid
  );
endinterface

// File: rtl/rs_chien_seq.sv
// Multicycle Chien search. Accepts one error-locator polynomial Λ(x) per
// transaction, evaluates Λ(α^-p) for p = 0..N_LEN-1 at P positions per cycle
// and returns the ascending list of roots, the root count and a fail flag.
// Ports:
//   aclk     clock
//   aresetn  asynchronous active-low reset
//   bus      rs_chien_seq_if slave modport (input/output handshakes + results)
// GF(2^m) with α = x requires SYMB_WIDTH >= 2.
module rs_chien_seq #(
  parameter int unsigned SYMB_WIDTH = 8,
  parameter int unsigned PRIM_POLY  = 'h11D,
  parameter int unsigned T_LEN      = 8,
  parameter int unsigned N_LEN      = 255,
  parameter int unsigned P          = 8,
  parameter bit          EARLY_STOP = 1'b0
) (
  input logic          aclk,
  input logic          aresetn,
  rs_chien_seq_if.slave bus
);

  localparam int unsigned POS_W = (N_LEN > 1) ? $clog2(N_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(T_LEN + 2);
  localparam int unsigned Order = (1 << SYMB_WIDTH) - 1;
  localparam int unsigned BaseW = $clog2(N_LEN + P + 1);
  localparam logic [SYMB_WIDTH:0] Poly = PRIM_POLY[SYMB_WIDTH:0];

  typedef logic [SYMB_WIDTH-1:0] sym_t;

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  // Shift-and-add GF multiply; used with a constant operand it reduces to XOR trees.
  function automatic sym_t gf_mul(sym_t a, sym_t b);
    logic [SYMB_WIDTH:0] acc;
    sym_t                res;
    res = '0;
    acc = {1'b0, a};
    for (int k = 0; k < SYMB_WIDTH; k++) begin
      if (b[k]) res ^= acc[SYMB_WIDTH-1:0];
      acc = acc << 1;
      if (acc[SYMB_WIDTH]) acc ^= Poly;
    end
    return res;
  endfunction

  // α^e by square-and-multiply, evaluated at elaboration.
  function automatic sym_t gf_alpha_pow(int unsigned e);
    sym_t res;
    sym_t sq;
    res = sym_t'(1);
    sq  = sym_t'(2);
    for (int k = 0; k < 32; k++) begin
      if (e[k]) res = gf_mul(res, sq);
      sq = gf_mul(sq, sq);
    end
    return res;
  endfunction

  // Exponent of α^-e within the multiplicative group.
  function automatic int unsigned neg_exp(int unsigned e);
    return (Order - (e % Order)) % Order;
  endfunction

  state_e              state_q, state_d;
  sym_t                r_q     [T_LEN+1];
  sym_t                r_d     [T_LEN+1];
  sym_t                r_next  [T_LEN+1];
  logic [BaseW-1:0]    base_q, base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    deg_q, deg_d;
  logic                lam0_zero_q, lam0_zero_d;
  logic                finish_q, finish_d;
  logic [POS_W-1:0]    pos_q   [T_LEN];
  logic [POS_W-1:0]    pos_d   [T_LEN];
  logic [T_LEN-1:0]    vld_q, vld_d;
  logic                fail_q, fail_d;

  sym_t                term    [P][T_LEN+1];
  sym_t                v       [P];
  logic [31:0]         lane_pos [P];
  logic [P-1:0]        lane_root;
  logic                last_cycle;
  logic [T_LEN*POS_W-1:0] pos_flat;

  // Constant multipliers: lane i uses α^(-j*i), the register update α^(-j*P).
  for (genvar gj = 0; gj <= T_LEN; gj++) begin : g_coef
    localparam sym_t StepC = gf_alpha_pow(neg_exp(gj * P));
    assign r_next[gj] = gf_mul(r_q[gj], StepC);
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      localparam sym_t LaneC = gf_alpha_pow(neg_exp(gj * gi));
      assign term[gi][gj] = gf_mul(r_q[gj], LaneC);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < P; i++) begin
      v[i] = '0;
      for (int unsigned j = 0; j <= T_LEN; j++) v[i] ^= term[i][j];
    end
  end

  // Lanes past the code end would see wrapped positions and are masked.
  always_comb begin
    lane_root = '0;
    for (int unsigned i = 0; i < P; i++) begin
      lane_pos[i]  = 32'(base_q) + i;
      lane_root[i] = (v[i] == '0) && (lane_pos[i] < N_LEN);
    end
    last_cycle = (32'(base_q) + P) >= N_LEN;
  end

  always_comb begin
    int unsigned cnt_ins;
    state_d     = state_q;
    r_d         = r_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    deg_d       = deg_q;
    lam0_zero_d = lam0_zero_q;
    finish_d    = finish_q;
    pos_d       = pos_q;
    vld_d       = vld_q;
    fail_d      = fail_q;
    cnt_ins     = 0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StEval;
          deg_d   = '0;
          for (int unsigned j = 0; j <= T_LEN; j++) begin
            r_d[j] = bus.lambda_i[j*SYMB_WIDTH +: SYMB_WIDTH];
            if (bus.lambda_i[j*SYMB_WIDTH +: SYMB_WIDTH] != '0) deg_d = CNT_W'(j);
          end
          lam0_zero_d = (bus.lambda_i[SYMB_WIDTH-1:0] == '0);
          base_d      = '0;
          cnt_d       = '0;
          pos_d       = '{default: '0};
          vld_d       = '0;
          fail_d      = 1'b0;
          finish_d    = 1'b0;
        end
      end

      StEval: begin
        if (finish_q) begin
          // Wrap-up cycle: the search is over, register the verdict.
          state_d = StDone;
          fail_d  = lam0_zero_q | (cnt_q != deg_q);
        end else begin
          // Lane-order insertion keeps the slot list ascending.
          cnt_ins = 32'(cnt_q);
          for (int unsigned i = 0; i < P; i++) begin
            if (lane_root[i]) begin
              for (int unsigned k = 0; k < T_LEN; k++) begin
                if (cnt_ins == k) begin
                  pos_d[k] = lane_pos[i][POS_W-1:0];
                  vld_d[k] = 1'b1;
                end
              end
              if (cnt_ins < T_LEN + 1) cnt_ins++;
            end
          end
          cnt_d  = CNT_W'(cnt_ins);
          r_d    = r_next;
          base_d = base_q + BaseW'(P);
          if (last_cycle || (EARLY_STOP && (cnt_d == deg_q) && (deg_q != '0))) begin
            finish_d = 1'b1;
          end
        end
      end

      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      r_q         <= '{default: '0};
      base_q      <= '0;
      cnt_q       <= '0;
      deg_q       <= '0;
      lam0_zero_q <= 1'b0;
      finish_q    <= 1'b0;
      pos_q       <= '{default: '0};
      vld_q       <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      deg_q       <= deg_d;
      lam0_zero_q <= lam0_zero_d;
      finish_q    <= finish_d;
      pos_q       <= pos_d;
      vld_q       <= vld_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    pos_flat = '0;
    for (int unsigned k = 0; k < T_LEN; k++) pos_flat[k*POS_W +: POS_W] = pos_q[k];
  end

  assign bus.in_ready      = (state_q == StIdle);
  assign bus.out_valid     = (state_q == StDone);
  assign bus.err_pos_o     = pos_flat;
  assign bus.err_pos_vld_o = vld_q;
  assign bus.err_cnt_o     = cnt_q;
  assign bus.fail_o        = fail_q;

endmodule

// File: tb/tb_rs_chien_seq.sv
// Directed bench for rs_chien_seq over GF(2^8)/0x11D, T_LEN=8. Five DUT
// configurations share one stimulus driver selected by sel:
//   0 default (N=255,P=8), 1 EARLY_STOP, 2 N_LEN=200, 3 P=3, 4 P=1.
module tb_rs_chien_seq;

  typedef logic [71:0] lam_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic [71:0] lam;
    logic [3:0]  cnt;
    logic [7:0]  mask;
    logic [63:0] pos;
    logic        fail;
    logic [15:0] lat;
  } vec_t;

  logic aclk;
  logic aresetn;
  logic [2:0] sel;
  lam_t lam;
  logic in_valid;
  logic out_ready;

  int n_cmp;
  int n_bad;

  rs_chien_seq_if #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(255)) if0 ();
  rs_chien_seq_if #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(255)) if1 ();
  rs_chien_seq_if #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(200)) if2 ();
  rs_chien_seq_if #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(255)) if3 ();
  rs_chien_seq_if #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(255)) if4 ();

  rs_chien_seq u_def (.aclk(aclk), .aresetn(aresetn), .bus(if0));
  rs_chien_seq #(.EARLY_STOP(1'b1)) u_es (.aclk(aclk), .aresetn(aresetn), .bus(if1));
  rs_chien_seq #(.N_LEN(200)) u_sh (.aclk(aclk), .aresetn(aresetn), .bus(if2));
  rs_chien_seq #(.P(3)) u_p3 (.aclk(aclk), .aresetn(aresetn), .bus(if3));
  rs_chien_seq #(.P(1)) u_p1 (.aclk(aclk), .aresetn(aresetn), .bus(if4));

  assign if0.lambda_i = lam;
  assign if1.lambda_i = lam;
  assign if2.lambda_i = lam;
  assign if3.lambda_i = lam;
  assign if4.lambda_i = lam;
  assign if0.in_valid = in_valid && (sel == 3'd0);
  assign if1.in_valid = in_valid && (sel == 3'd1);
  assign if2.in_valid = in_valid && (sel == 3'd2);
  assign if3.in_valid = in_valid && (sel == 3'd3);
  assign if4.in_valid = in_valid && (sel == 3'd4);
  assign if0.out_ready = (sel == 3'd0) ? out_ready : 1'b1;
  assign if1.out_ready = (sel == 3'd1) ? out_ready : 1'b1;
  assign if2.out_ready = (sel == 3'd2) ? out_ready : 1'b1;
  assign if3.out_ready = (sel == 3'd3) ? out_ready : 1'b1;
  assign if4.out_ready = (sel == 3'd4) ? out_ready : 1'b1;

  logic        o_in_ready;
  logic        o_out_valid;
  logic        o_fail;
  logic [63:0] o_pos;
  logic [7:0]  o_mask;
  logic [3:0]  o_cnt;

  always_comb begin
    case (sel)
      3'd1: begin
        o_in_ready = if1.in_ready; o_out_valid = if1.out_valid; o_fail = if1.fail_o;
        o_pos = if1.err_pos_o; o_mask = if1.err_pos_vld_o; o_cnt = if1.err_cnt_o;
      end
      3'd2: begin
        o_in_ready = if2.in_ready; o_out_valid = if2.out_valid; o_fail = if2.fail_o;
        o_pos = if2.err_pos_o; o_mask = if2.err_pos_vld_o; o_cnt = if2.err_cnt_o;
      end
      3'd3: begin
        o_in_ready = if3.in_ready; o_out_valid = if3.out_valid; o_fail = if3.fail_o;
        o_pos = if3.err_pos_o; o_mask = if3.err_pos_vld_o; o_cnt = if3.err_cnt_o;
      end
      3'd4: begin
        o_in_ready = if4.in_ready; o_out_valid = if4.out_valid; o_fail = if4.fail_o;
        o_pos = if4.err_pos_o; o_mask = if4.err_pos_vld_o; o_cnt = if4.err_cnt_o;
      end
      default: begin
        o_in_ready = if0.in_ready; o_out_valid = if0.out_valid; o_fail = if0.fail_o;
        o_pos = if0.err_pos_o; o_mask = if0.err_pos_vld_o; o_cnt = if0.err_cnt_o;
      end
    endcase
  end

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference GF(2^8) arithmetic used only to build Λ from its roots.
  function automatic logic [7:0] xtime(logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1D) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] res;
    logic [7:0] t;
    res = 8'h00;
    t   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) res ^= t;
      t = xtime(t);
    end
    return res;
  endfunction

  function automatic logic [7:0] apow(int e);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < e; k++) r = xtime(r);
    return r;
  endfunction

  // Λ(x) = Π (1 + α^e x), which vanishes at x = α^-e, i.e. position e.
  function automatic lam_t roots_poly(int n, int r[8]);
    logic [7:0] c [9];
    logic [7:0] a;
    lam_t       res;
    for (int j = 0; j < 9; j++) c[j] = 8'h00;
    c[0] = 8'h01;
    for (int k = 0; k < n; k++) begin
      a = apow(r[k]);
      for (int j = 8; j >= 1; j--) c[j] = c[j] ^ gmul(c[j-1], a);
    end
    for (int j = 0; j < 9; j++) res[j*8 +: 8] = c[j];
    return res;
  endfunction

  function automatic logic [63:0] pk(int s[8]);
    logic [63:0] res;
    for (int k = 0; k < 8; k++) res[k*8 +: 8] = 8'(s[k]);
    return res;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic accept_vec(input vec_t v, input string tag);
    int w;
    sel = v.sel;
    lam = v.lam;
    w = 0;
    while (!o_in_ready && w < 10) begin
      @(posedge aclk);
      #1;
      w++;
    end
    check({tag, " in_ready idle"}, 72'(o_in_ready), 72'(1));
    in_valid = 1'b1;
    @(posedge aclk);
    #1;
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, 72'(o_in_ready), 72'(0));
  endtask

  task automatic wait_result(input vec_t v, input string tag);
    int  n;
    bit  got;
    n   = 1;
    got = 1'b0;
    while (!got && n < 400) begin
      @(posedge aclk);
      #1;
      if (o_out_valid) got = 1'b1;
      else n++;
    end
    check({tag, " latency"}, 72'(n), 72'(v.lat));
    check({tag, " cnt"}, 72'(o_cnt), 72'(v.cnt));
    check({tag, " mask"}, 72'(o_mask), 72'(v.mask));
    check({tag, " pos"}, 72'(o_pos), 72'(v.pos));
    check({tag, " fail"}, 72'(o_fail), 72'(v.fail));
  endtask

  vec_t vecs[$];

  task automatic add(input int s, input lam_t l, input int c, input logic [7:0] m,
                     input logic [63:0] p, input bit f, input int lt);
    vec_t v;
    v.sel = 3'(s); v.lam = l; v.cnt = 4'(c); v.mask = m; v.pos = p; v.fail = f;
    v.lat = 16'(lt);
    vecs.push_back(v);
  endtask

  initial begin
    vec_t three;
    vec_t single;
    n_cmp     = 0;
    n_bad     = 0;
    sel       = 3'd0;
    lam       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aresetn   = 1'b0;

    add(0, 72'h1, 0, 8'h00, 64'h0, 1'b0, 33);
    add(0, roots_poly(1, '{5, 0, 0, 0, 0, 0, 0, 0}), 1, 8'h01, pk('{5, 0, 0, 0, 0, 0, 0, 0}),
        1'b0, 33);
    add(1, roots_poly(1, '{5, 0, 0, 0, 0, 0, 0, 0}), 1, 8'h01, pk('{5, 0, 0, 0, 0, 0, 0, 0}),
        1'b0, 2);
    add(0, roots_poly(3, '{3, 100, 254, 0, 0, 0, 0, 0}), 3, 8'h07,
        pk('{3, 100, 254, 0, 0, 0, 0, 0}), 1'b0, 33);
    add(3, roots_poly(3, '{3, 100, 254, 0, 0, 0, 0, 0}), 3, 8'h07,
        pk('{3, 100, 254, 0, 0, 0, 0, 0}), 1'b0, 86);
    add(4, roots_poly(3, '{3, 100, 254, 0, 0, 0, 0, 0}), 3, 8'h07,
        pk('{3, 100, 254, 0, 0, 0, 0, 0}), 1'b0, 256);
    add(1, roots_poly(3, '{3, 100, 254, 0, 0, 0, 0, 0}), 3, 8'h07,
        pk('{3, 100, 254, 0, 0, 0, 0, 0}), 1'b0, 33);
    add(2, roots_poly(2, '{3, 250, 0, 0, 0, 0, 0, 0}), 1, 8'h01,
        pk('{3, 0, 0, 0, 0, 0, 0, 0}), 1'b1, 26);
    add(2, roots_poly(2, '{199, 0, 0, 0, 0, 0, 0, 0}), 2, 8'h03,
        pk('{0, 199, 0, 0, 0, 0, 0, 0}), 1'b0, 26);
    // Λ = α^5·x: Λ_0 = 0
    add(0, 72'h2000, 0, 8'h00, 64'h0, 1'b1, 33);
    // Λ all zero: every position is a root, count saturates
    add(0, 72'h0, 9, 8'hFF, pk('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b1, 33);
    add(0, roots_poly(8, '{0, 1, 2, 50, 100, 150, 200, 254}), 8, 8'hFF,
        pk('{0, 1, 2, 50, 100, 150, 200, 254}), 1'b0, 33);
    // Λ = 1 + x^2 = (1+x)^2: one distinct root at 0, degree 2
    add(0, 72'h1_0001, 1, 8'h01, pk('{0, 0, 0, 0, 0, 0, 0, 0}), 1'b1, 33);
    add(0, roots_poly(3, '{9, 7, 8, 0, 0, 0, 0, 0}), 3, 8'h07,
        pk('{7, 8, 9, 0, 0, 0, 0, 0}), 1'b0, 33);
    add(1, roots_poly(3, '{2, 0, 1, 0, 0, 0, 0, 0}), 3, 8'h07,
        pk('{0, 1, 2, 0, 0, 0, 0, 0}), 1'b0, 2);
    add(1, 72'h1, 0, 8'h00, 64'h0, 1'b0, 33);

    three  = vecs[3];
    single = vecs[1];

    // Reset values
    #2;
    check("reset in_ready", 72'(o_in_ready), 72'(1));
    check("reset out_valid", 72'(o_out_valid), 72'(0));
    check("reset cnt", 72'(o_cnt), 72'(0));
    check("reset mask", 72'(o_mask), 72'(0));
    check("reset pos", 72'(o_pos), 72'(0));
    check("reset fail", 72'(o_fail), 72'(0));
    #10;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      accept_vec(vecs[i], $sformatf("v%0d", i));
      wait_result(vecs[i], $sformatf("v%0d", i));
    end

    // Backpressure: hold result, ignore a second request, then release
    out_ready = 1'b0;
    accept_vec(three, "bp");
    wait_result(three, "bp");
    lam      = 72'h1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge aclk);
      #1;
      check($sformatf("bp hold%0d out_valid", c), 72'(o_out_valid), 72'(1));
      check($sformatf("bp hold%0d in_ready", c), 72'(o_in_ready), 72'(0));
      check($sformatf("bp hold%0d pos", c), 72'(o_pos), 72'(three.pos));
      check($sformatf("bp hold%0d cnt", c), 72'(o_cnt), 72'(three.cnt));
      check($sformatf("bp hold%0d fail", c), 72'(o_fail), 72'(three.fail));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("bp release out_valid", 72'(o_out_valid), 72'(0));
    check("bp release in_ready", 72'(o_in_ready), 72'(1));

    // Reset during EVAL cycle 5 discards the transaction
    accept_vec(three, "rst");
    repeat (4) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst in_ready", 72'(o_in_ready), 72'(1));
    check("rst out_valid", 72'(o_out_valid), 72'(0));
    check("rst cnt", 72'(o_cnt), 72'(0));
    check("rst mask", 72'(o_mask), 72'(0));
    check("rst pos", 72'(o_pos), 72'(0));
    check("rst fail", 72'(o_fail), 72'(0));
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    accept_vec(single, "post");
    wait_result(single, "post");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
